key_debouncer: RTL and testbench
================================

# key_debouncer

Conditions raw board push-buttons before they reach lab logic: per-key two-flop synchronizer, counter-based debounce filter, and registered press/release edge pulses. Sits directly between the board `key` pins and the lab top's `key` input; lab code then sees clean levels instead of bouncing, asynchronous contacts. Handles optional active-low key wiring so downstream logic always sees 1 = pressed.

## Interface

- `clk_mhz`, 50: clock frequency in MHz; used only to derive the default `debounce_cycles`.
- `w_key`, 4: number of keys, each filtered independently.
- `debounce_us`, 10000: debounce window in microseconds.
- `debounce_cycles`, `clk_mhz * debounce_us`: window in clock cycles (N); override directly for simulation; must be >= 1.
- `active_low`, 1: 1 = raw pin reads 0 when pressed, so the block inverts the input; 0 = no inversion.

- `clk`  input  1  system clock; all state on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `key_raw`  input  w_key  raw asynchronous key pins.
- `key_level`  output  w_key  debounced level, 1 = pressed.
- `key_press`  output  w_key  one-cycle pulse on debounced 0->1.
- `key_release`  output  w_key  one-cycle pulse on debounced 1->0.

## Operation

- Per key i: `p = key_raw[i] ^ active_low`. Two flops `s1 <= p`, `s2 <= s1`; only `s2` is used downstream.
- Per key counter `cnt`, width `$clog2(debounce_cycles + 1)`, plus a stable register `stb` (drives `key_level[i]`).
- Each cycle:
  - `s2 == stb`: `cnt <= 0`.
  - `s2 != stb` and `cnt == debounce_cycles - 1`: `stb <= s2`, `cnt <= 0`, assert the matching pulse next cycle.
  - otherwise: `cnt <= cnt + 1`.
- Acceptance requires N consecutive cycles of `s2 != stb`. Any single cycle of agreement clears the count, so no partial credit carries over.
- `key_press[i]` is a registered signal, high for exactly the one cycle in which `stb` first reads 1. `key_release[i]` is the same for `stb` first reading 0. Never both in one cycle for the same key.
- Keys are fully independent. Any combination of keys may change or pulse in the same cycle.
- Counter never exceeds `debounce_cycles - 1`, so there is no wrap-around.

## Timing

- Reset (`rst` high at an edge): `s1`, `s2`, `stb`, `cnt` are cleared to 0. `key_level`, `key_press`, `key_release` are 0 from the cycle after that edge and stay 0 while `rst` is held.
- A key held pressed through reset is treated as a fresh press after reset release. Expect a `key_press` pulse N+2 edges after the first non-reset edge.
- Latency: `p` settles before edge 0. `s2` reflects it after edge 1. `stb`, `key_level` and the pulse update after edge N+1. Total N+2 rising edges from settled input to output.
- Glitch of fewer than N consecutive differing `s2` cycles: no output change, no pulse.
- Reset mid-count: `cnt` is cleared and no pulse is emitted. Counting restarts from 0 after reset release.
- No handshake. Pulses are not held or queued; consumers must sample every cycle.

## Test plan

Bench uses `debounce_cycles` = 4 and `active_low` = 0 unless stated.

- Clean press, key 0: `key_raw` 0000->0001 before edge 0 -> `key_level` = 0001 after edge 5. `key_press` = 0001 for exactly that one cycle. `key_release` stays 0. Other bits stay 0.
- Bounce: 3-cycle high glitch on key 1 -> `key_level[1]` stays 0, no pulses. Then toggle key 1 every 2 cycles for 10 cycles and hold high -> exactly one `key_press[1]`, 6 edges after the final transition.
- Release: key 0 pressed and stable, raw drops to 0 -> `key_level[0]` falls after edge 5. `key_release[0]` is a single one-cycle pulse. No `key_press`.
- Simultaneous: key 2 pressed and key 3 released on the same cycle (both previously stable) -> `key_press` = 0100 and `key_release` = 1000 in the same cycle, 6 edges later.
- Reset: `key_raw` = 1111 held while `rst` is high for 3 cycles -> all outputs 0 during reset. After release, `key_level` = 1111 with `key_press` = 1111 pulsed once, 6 edges after the first non-reset edge. Also assert `rst` at `cnt` = 2 -> no pulse, and the count restarts from 0.
- Polarity, `active_low` = 1: `key_raw` idles at 1111 and key 0 is driven to 0 -> `key_level` = 0001 and `key_press[0]` pulses, 6 edges later.

Source files
------------

// File: rtl/key_debouncer_if.sv
// rtl/key_debouncer_if.sv - key pin and debounced key signal bundle
interface key_debouncer_if #(
  parameter int w_key = 4
);
  logic [w_key-1:0] key_raw;
  logic [w_key-1:0] key_level;
  logic [w_key-1:0] key_press;
  logic [w_key-1:0] key_release;

  // Board / lab side: drives the raw pins, consumes clean levels and pulses.
  modport master (
    output key_raw,
    input  key_level,
    input  key_press,
    input  key_release
  );

  // Debouncer side.
  modport slave (
    input  key_raw,
    output key_level,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - per-key synchronizer, counter debounce filter and edge pulses
module key_debouncer #(
  parameter int clk_mhz         = 50,
  parameter int w_key           = 4,
  parameter int debounce_us     = 10000,
  parameter int debounce_cycles = clk_mhz * debounce_us,
  parameter bit active_low      = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  key_debouncer_if.slave bus
);

  // Counter only has to reach debounce_cycles - 1, so it can never wrap.
  localparam int               cw       = $clog2(debounce_cycles + 1);
  localparam logic [cw-1:0]    cnt_last = cw'(debounce_cycles - 1);
  localparam logic [w_key-1:0] invert   = active_low ? '1 : '0;

  logic [w_key-1:0] s1;
  logic [w_key-1:0] s2;
  logic [w_key-1:0] stb_q;
  logic [w_key-1:0] stb_d;
  logic [w_key-1:0] press_q;
  logic [w_key-1:0] press_d;
  logic [w_key-1:0] rel_q;
  logic [w_key-1:0] rel_d;
  logic [cw-1:0]    cnt_q [w_key];
  logic [cw-1:0]    cnt_d [w_key];

  // Normalise polarity so 1 = pressed, then two-flop synchronize the async pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.key_raw ^ invert;
      s2 <= s1;
    end
  end

  // Accept a new level only after debounce_cycles consecutive disagreeing cycles;
  // any agreeing cycle throws the partial count away.
  always_comb begin
    stb_d   = stb_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < w_key; i++) begin
      cnt_d[i] = '0;
      if (s2[i] != stb_q[i]) begin
        if (cnt_q[i] == cnt_last) begin
          stb_d[i]   = s2[i];
          press_d[i] = s2[i];
          rel_d[i]   = ~s2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Filter state and pulses update together, so a pulse lines up with the
  // first cycle of its new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      stb_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < w_key; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stb_q   <= stb_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < w_key; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.key_level   = stb_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = rel_q;

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - self-checking bench for key_debouncer against a run-length model
module tb_key_debouncer;

  localparam int n_db = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  key_debouncer_if #(.w_key(4)) bus_a ();
  key_debouncer_if #(.w_key(4)) bus_b ();

  key_debouncer #(
    .w_key(4), .debounce_cycles(n_db), .active_low(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );

  key_debouncer #(
    .w_key(4), .debounce_cycles(n_db), .active_low(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  always #5 clk = ~clk;

  // Model: the key's pressed state, seen two edges late, must disagree with the
  // accepted level for n_db edges in a row before the level flips.
  logic [7:0] hist [$];
  logic [3:0] m_lvl   [2];
  logic [3:0] m_press [2];
  logic [3:0] m_rel   [2];
  int         run     [2][4];

  always @(posedge clk) begin
    logic [7:0] old;
    if (rst) begin
      hist.delete();
      hist.push_back(8'h00);
      hist.push_back(8'h00);
      for (int d = 0; d < 2; d++) begin
        m_lvl[d] = '0; m_press[d] = '0; m_rel[d] = '0;
        for (int i = 0; i < 4; i++) run[d][i] = 0;
      end
    end else begin
      old = hist.pop_front();
      for (int d = 0; d < 2; d++) begin
        m_press[d] = '0;
        m_rel[d]   = '0;
        for (int i = 0; i < 4; i++) begin
          if (old[d*4+i] != m_lvl[d][i]) run[d][i] = run[d][i] + 1;
          else run[d][i] = 0;
          if (run[d][i] == n_db) begin
            m_lvl[d][i] = old[d*4+i];
            if (old[d*4+i]) m_press[d][i] = 1'b1;
            else m_rel[d][i] = 1'b1;
            run[d][i] = 0;
          end
        end
      end
      hist.push_back({bus_b.key_raw ^ 4'hF, bus_a.key_raw});
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("a_level",   bus_a.key_level,   m_lvl[0]);
      check("a_press",   bus_a.key_press,   m_press[0]);
      check("a_release", bus_a.key_release, m_rel[0]);
      check("b_level",   bus_b.key_level,   m_lvl[1]);
      check("b_press",   bus_b.key_press,   m_press[1]);
      check("b_release", bus_b.key_release, m_rel[1]);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus_a.key_raw = 4'h0;
    bus_b.key_raw = 4'hF;
    rst = 1'b1;
    step(3);
    check("reset_level", bus_a.key_level, 4'h0);
    check("reset_press", bus_a.key_press, 4'h0);
    cmp_en = 1'b1;
    rst = 1'b0;
    step(8);

    // Clean press on key 0.
    bus_a.key_raw = 4'b0001;
    step(5);
    check("press_early", bus_a.key_press, 4'b0000);
    check("press_early_lvl", bus_a.key_level, 4'b0000);
    step(1);
    check("press_level", bus_a.key_level, 4'b0001);
    check("press_pulse", bus_a.key_press, 4'b0001);
    check("press_norel", bus_a.key_release, 4'b0000);
    step(1);
    check("press_once", bus_a.key_press, 4'b0000);

    // Three-cycle glitch on key 1 is rejected.
    bus_a.key_raw = 4'b0011;
    step(3);
    bus_a.key_raw = 4'b0001;
    step(10);
    check("glitch_level", bus_a.key_level, 4'b0001);

    // Toggle key 1 every 2 cycles, final transition is to high.
    for (int t = 0; t < 4; t++) begin
      bus_a.key_raw[1] = ~bus_a.key_raw[1];
      step(2);
    end
    bus_a.key_raw[1] = 1'b1;
    step(5);
    check("bounce_early", bus_a.key_press, 4'b0000);
    check("bounce_nolvl", bus_a.key_level, 4'b0001);
    step(1);
    check("bounce_press", bus_a.key_press, 4'b0010);
    check("bounce_level", bus_a.key_level, 4'b0011);
    step(4);

    // Release key 0.
    bus_a.key_raw = 4'b0010;
    step(5);
    check("rel_early", bus_a.key_level, 4'b0011);
    step(1);
    check("rel_level", bus_a.key_level, 4'b0010);
    check("rel_pulse", bus_a.key_release, 4'b0001);
    check("rel_nopress", bus_a.key_press, 4'b0000);
    step(1);
    check("rel_once", bus_a.key_release, 4'b0000);

    // Key 2 pressed while key 3 released in the same cycle.
    bus_a.key_raw = 4'b1010;
    step(10);
    bus_a.key_raw = 4'b0110;
    step(6);
    check("sim_press", bus_a.key_press, 4'b0100);
    check("sim_release", bus_a.key_release, 4'b1000);
    check("sim_level", bus_a.key_level, 4'b0110);
    step(2);

    // All keys held through reset.
    bus_a.key_raw = 4'b1111;
    rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step(1);
      check("rst_hold_level", bus_a.key_level, 4'b0000);
      check("rst_hold_rel", bus_a.key_release, 4'b0000);
    end
    rst = 1'b0;
    step(5);
    check("rst_early", bus_a.key_press, 4'b0000);
    step(1);
    check("rst_press", bus_a.key_press, 4'b1111);
    check("rst_level", bus_a.key_level, 4'b1111);
    step(3);

    // Reset at cnt = 2 during a release: no pulse, count restarts.
    bus_a.key_raw = 4'b0000;
    step(4);
    rst = 1'b1;
    step(1);
    check("midrst_rel", bus_a.key_release, 4'b0000);
    check("midrst_level", bus_a.key_level, 4'b0000);
    rst = 1'b0;
    step(8);
    check("midrst_after", bus_a.key_release, 4'b0000);
    bus_a.key_raw = 4'b0001;
    step(5);
    check("restart_early", bus_a.key_press, 4'b0000);
    step(1);
    check("restart_press", bus_a.key_press, 4'b0001);
    step(4);

    // Active-low instance: key 0 pin pulled low.
    bus_b.key_raw = 4'b1110;
    step(5);
    check("pol_early", bus_b.key_press, 4'b0000);
    step(1);
    check("pol_level", bus_b.key_level, 4'b0001);
    check("pol_press", bus_b.key_press, 4'b0001);
    step(4);

    // Randomized segments with occasional resets.
    for (int s = 0; s < 300; s++) begin
      bus_a.key_raw = 4'($urandom);
      bus_b.key_raw = 4'($urandom);
      if ($urandom_range(0, 29) == 0) rst = 1'b1;
      if ($urandom_range(0, 2) == 0) step($urandom_range(5, 12));
      else step($urandom_range(1, 4));
      rst = 1'b0;
    end
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
